// File: rtl/arith_pkg.sv
// Shared arithmetic-unit definitions: FSM encoding and default operand width.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package arith_pkg;

   // Default operand/result width for the arithmetic blocks.
   localparam int DEF_BITS = 8;

   // Control FSM states of the multi-cycle arithmetic blocks.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } div_state_e;

endpackage

// File: rtl/seq_divider_if.sv
// Handshake and operand/result bus between the controlling FSM and the divider.
// Latency: n/a (wires only).
// Backpressure: none; start is only honoured while busy is low.
interface seq_divider_if #(
   parameter int BITS = arith_pkg::DEF_BITS
);
   logic            start;
   logic [BITS-1:0] dividend;
   logic [BITS-1:0] divisor;
   logic            busy;
   logic            done;
   logic [BITS-1:0] quotient;
   logic [BITS-1:0] remainder;
   logic            div_zero;

   // Controller side: issues requests, observes status and results.
   modport master (
      output start, dividend, divisor,
      input  busy, done, quotient, remainder, div_zero
   );

   // Divider side: accepts requests, returns status and results.
   modport slave (
      input  start, dividend, divisor,
      output busy, done, quotient, remainder, div_zero
   );
endinterface

// File: rtl/seq_divider_div_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract, restore on borrow.
// Latency: purely combinational.
// Backpressure: n/a.
module div_step #(
   parameter int BITS = arith_pkg::DEF_BITS
) (
   input  logic [BITS:0]   r_in,
   input  logic            d_bit,
   input  logic [BITS-1:0] divisor,
   output logic [BITS:0]   r_out,
   output logic            q_bit
);
   // One guard bit above the shifted remainder so the borrow shows up as the sign.
   logic [BITS+1:0] shifted;
   logic [BITS+1:0] trial;

   // Shift, trial-subtract, and keep the difference only when it did not go negative.
   always_comb begin
      shifted = {r_in, d_bit};
      trial   = shifted - {2'b00, divisor};
      q_bit   = ~trial[BITS+1];
      r_out   = q_bit ? trial[BITS:0] : shifted[BITS:0];
   end
endmodule

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider, one quotient bit per clock.
// Latency: done BITS+1 cycles after an accepted start (1 cycle for divide-by-zero).
// Backpressure: start ignored while busy or during the done cycle; no queuing.
module seq_divider
   import arith_pkg::*;
#(
   parameter int BITS = DEF_BITS
) (
   input  logic         clk,
   input  logic         reset,
   seq_divider_if.slave bus
);
   localparam int CNTW = $clog2(BITS + 1);
   localparam logic [CNTW-1:0] LAST_STEP = CNTW'(BITS - 1);

   div_state_e      state_q, state_d;
   logic [CNTW-1:0] cnt_q, cnt_d;
   logic [BITS:0]   r_q, r_d;       // partial remainder, one extra bit for the borrow
   logic [BITS-1:0] q_q, q_d;       // dividend shifting out the top, quotient bits in the bottom
   logic [BITS-1:0] dvs_q, dvs_d;
   logic [BITS-1:0] quot_q, quot_d;
   logic [BITS-1:0] rem_q, rem_d;
   logic            dz_q, dz_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;

   logic [BITS:0]   step_r;
   logic            step_q;
   logic [BITS-1:0] q_shift;

   div_step #(.BITS(BITS)) u_step (
      .r_in    (r_q),
      .d_bit   (q_q[BITS-1]),
      .divisor (dvs_q),
      .r_out   (step_r),
      .q_bit   (step_q)
   );

   assign q_shift = {q_q[BITS-2:0], step_q};

   // Next-state logic: request acceptance, one division step per RUN cycle, result load.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      r_d     = r_q;
      q_d     = q_q;
      dvs_d   = dvs_q;
      quot_d  = quot_q;
      rem_d   = rem_q;
      dz_d    = dz_q;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               if (bus.divisor != '0) begin
                  r_d     = '0;
                  q_d     = bus.dividend;
                  dvs_d   = bus.divisor;
                  cnt_d   = '0;
                  busy_d  = 1'b1;
                  state_d = ST_RUN;
               end else begin
                  // Divide-by-zero short-circuits straight to the result.
                  quot_d  = '1;
                  rem_d   = bus.dividend;
                  dz_d    = 1'b1;
                  done_d  = 1'b1;
                  state_d = ST_DONE;
               end
            end
         end
         ST_RUN: begin
            r_d   = step_r;
            q_d   = q_shift;
            cnt_d = cnt_q + CNTW'(1);
            if (cnt_q == LAST_STEP) begin
               // Results become visible only together with the done pulse.
               quot_d  = q_shift;
               rem_d   = step_r[BITS-1:0];
               dz_d    = 1'b0;
               done_d  = 1'b1;
               state_d = ST_DONE;
            end else begin
               busy_d = 1'b1;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and registered outputs; synchronous reset aborts any operation in flight.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         r_q     <= '0;
         q_q     <= '0;
         dvs_q   <= '0;
         quot_q  <= '0;
         rem_q   <= '0;
         dz_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         r_q     <= r_d;
         q_q     <= q_d;
         dvs_q   <= dvs_d;
         quot_q  <= quot_d;
         rem_q   <= rem_d;
         dz_q    <= dz_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.quotient  = quot_q;
   assign bus.remainder = rem_q;
   assign bus.div_zero  = dz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed cases plus a random operand sweep.
// Latency: checks done timing and busy duration of every operation.
// Backpressure: exercises start while busy, back-to-back starts and reset mid-run.
module tb_seq_divider;
   localparam int BITS = 8;

   logic clk = 1'b0;
   logic reset;

   int n_checks = 0;
   int n_errors = 0;

   // Results the divider must be holding between done pulses.
   logic [BITS-1:0] prev_q;
   logic [BITS-1:0] prev_r;
   logic            prev_dz;

   seq_divider_if #(.BITS(BITS)) bus ();

   seq_divider #(.BITS(BITS)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Issue one request at the next falling edge and follow it to its done pulse.
   // poke_at > 0 re-asserts start with other operands that many cycles after acceptance.
   task automatic run_op(input logic [BITS-1:0] a, input logic [BITS-1:0] b,
                         input int poke_at, input logic [BITS-1:0] pa, input logic [BITS-1:0] pb);
      int              n;
      int              busy_n;
      int              done_at;
      bit              hold_bad;
      logic [BITS-1:0] exp_q;
      logic [BITS-1:0] exp_r;
      logic            exp_dz;
      @(negedge clk);
      check_eq("idle_busy", 32'(bus.busy), 0);
      check_eq("idle_done", 32'(bus.done), 0);
      bus.start    = 1'b1;
      bus.dividend = a;
      bus.divisor  = b;
      n        = 0;
      busy_n   = 0;
      done_at  = -1;
      hold_bad = 1'b0;
      while (done_at < 0 && n < 40) begin
         @(negedge clk);
         n++;
         bus.start = (n == poke_at);
         if (n == poke_at) begin
            bus.dividend = pa;
            bus.divisor  = pb;
         end
         if (bus.busy) busy_n++;
         if (bus.done) done_at = n;
         else if (bus.quotient !== prev_q || bus.remainder !== prev_r || bus.div_zero !== prev_dz)
            hold_bad = 1'b1;
      end
      bus.start = 1'b0;

      if (b == 0) begin
         exp_q  = '1;
         exp_r  = a;
         exp_dz = 1'b1;
      end else begin
         exp_q  = a / b;
         exp_r  = a % b;
         exp_dz = 1'b0;
      end
      check_eq("latency", 32'(done_at), (b == 0) ? 32'd1 : 32'(BITS + 1));
      check_eq("busy_cycles", 32'(busy_n), (b == 0) ? 32'd0 : 32'(BITS));
      check_eq("hold_stable", 32'(hold_bad), 0);
      check_eq("quotient", 32'(bus.quotient), 32'(exp_q));
      check_eq("remainder", 32'(bus.remainder), 32'(exp_r));
      check_eq("div_zero", 32'(bus.div_zero), 32'(exp_dz));
      if (b != 0) begin
         check_eq("invariant", 32'(int'(bus.quotient) * int'(b) + int'(bus.remainder)), 32'(a));
         check_eq("rem_lt_div", 32'(bus.remainder < b), 1);
      end
      prev_q  = exp_q;
      prev_r  = exp_r;
      prev_dz = exp_dz;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bit seen_done;
      logic [BITS-1:0] ra;
      logic [BITS-1:0] rb;

      reset        = 1'b1;
      bus.start    = 1'b0;
      bus.dividend = '0;
      bus.divisor  = '0;
      prev_q       = '0;
      prev_r       = '0;
      prev_dz      = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      check_eq("rst_busy", 32'(bus.busy), 0);
      check_eq("rst_done", 32'(bus.done), 0);
      check_eq("rst_quot", 32'(bus.quotient), 0);
      check_eq("rst_rem", 32'(bus.remainder), 0);
      check_eq("rst_dz", 32'(bus.div_zero), 0);

      // Directed operand patterns and boundaries.
      run_op(8'd100, 8'd7, 0, 8'd0, 8'd0);
      run_op(8'd255, 8'd1, 0, 8'd0, 8'd0);
      run_op(8'd5,   8'd9, 0, 8'd0, 8'd0);
      run_op(8'd0,   8'd3, 0, 8'd0, 8'd0);
      run_op(8'd200, 8'd0, 0, 8'd0, 8'd0);
      run_op(8'd255, 8'd255, 0, 8'd0, 8'd0);
      run_op(8'd254, 8'd255, 0, 8'd0, 8'd0);
      run_op(8'd0,   8'd0, 0, 8'd0, 8'd0);
      run_op(8'd128, 8'd2, 0, 8'd0, 8'd0);

      // Second start while busy must be ignored; then a back-to-back start is accepted.
      run_op(8'd100, 8'd7, 3, 8'd50, 8'd5);
      run_op(8'd50,  8'd5, 0, 8'd0, 8'd0);

      // Reset in the middle of an operation aborts it without a done pulse.
      @(negedge clk);
      bus.start    = 1'b1;
      bus.dividend = 8'd200;
      bus.divisor  = 8'd3;
      for (int n = 1; n <= 4; n++) begin
         @(negedge clk);
         bus.start = 1'b0;
         if (n == 4) begin
            check_eq("abort_busy_before", 32'(bus.busy), 1);
            reset = 1'b1;
         end
      end
      @(negedge clk);
      reset = 1'b0;
      check_eq("abort_busy", 32'(bus.busy), 0);
      check_eq("abort_done", 32'(bus.done), 0);
      check_eq("abort_quot", 32'(bus.quotient), 0);
      check_eq("abort_rem", 32'(bus.remainder), 0);
      check_eq("abort_dz", 32'(bus.div_zero), 0);
      seen_done = 1'b0;
      repeat (12) begin
         @(negedge clk);
         if (bus.done) seen_done = 1'b1;
      end
      check_eq("abort_no_done", 32'(seen_done), 0);
      prev_q  = '0;
      prev_r  = '0;
      prev_dz = 1'b0;
      run_op(8'd9, 8'd2, 0, 8'd0, 8'd0);

      // Random sweep, biased toward zero and tiny divisors.
      for (int i = 0; i < 2500; i++) begin
         ra = 8'($urandom_range(0, 255));
         case ($urandom_range(0, 15))
            0:       rb = 8'd0;
            1:       rb = 8'd1;
            2:       rb = 8'd255;
            default: rb = 8'($urandom_range(0, 255));
         endcase
         run_op(ra, rb, 0, 8'd0, 8'd0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
